memory_stage: RTL

Memory stage of the pipelined Y86-64 core: holds the M pipeline register (loaded from the execute stage's valE/cnd plus forwarded control), owns the byte-addressed data memory, performs the single load or store each instruction requires, and produces valM and the memory-stage status. Sits between execute and write-back; its M-register and m_ outputs feed write-back, forwarding muxes and pipeline control.

---
 rtl/memory_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed little-endian data
// memory, single load/store per instruction with address-range checking.
module memory_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_stall,
  input  logic        M_bubble,
  input  logic        wr_block,
  input  logic [1:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [1:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic        m_read,
  output logic        m_write
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_ADR = 2'd2;

  // Highest start address for which all 8 bytes still fit in memory
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  logic [7:0]        mem [MEM_BYTES];
  logic              is_read;
  logic              is_write;
  logic              addr_err;
  logic [63:0]       addr;
  logic [ADDR_W-1:0] idx;
  logic [63:0]       rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        M_stat  <= S_AOK;
        M_icode <= I_NOP;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= R_NONE;
        M_dstM  <= R_NONE;
      end else begin
        M_stat  <= e_stat;
        M_icode <= e_icode;
        M_cnd   <= e_cnd;
        M_valE  <= e_valE;
        M_valA  <= e_valA;
        M_dstE  <= e_dstE;
        M_dstM  <= e_dstM;
      end
    end
  end

  always_comb begin
    is_read  = (M_icode == I_MRMOVQ) || (M_icode == I_RET) || (M_icode == I_POPQ);
    is_write = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
    // ret and popq read through the old stack pointer carried in valA
    addr     = ((M_icode == I_RET) || (M_icode == I_POPQ)) ? M_valA : M_valE;
    addr_err = (is_read || is_write) && (addr > LAST_ADDR);
    idx      = addr[ADDR_W-1:0];
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[idx + ADDR_W'(i)];
    end
  end

  always_comb begin
    m_stat  = addr_err ? S_ADR : M_stat;
    m_valM  = (is_read && !addr_err) ? rdata : 64'd0;
    m_read  = is_read && !addr_err && (M_stat == S_AOK);
    m_write = is_write && !addr_err && (M_stat == S_AOK) && !wr_block && !rst;
  end

  // Contents survive reset; a stalled store simply rewrites the same bytes
  always_ff @(posedge clk) begin
    if (m_write) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + ADDR_W'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

endmodule
